serial_pattern_tx: RTL and testbench



---
 rtl/serial_pattern_tx.sv | 160 ++++++++++++++++
 tb/tb_serial_pattern_tx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern transmitter: sends a latched pattern MSB-first on x_out,
// holding each bit CLKS_PER_BIT clocks, with optional repeats separated by idle gaps.
module serial_pattern_tx #(
   parameter int   PAT_W        = 8,
   parameter int   CLKS_PER_BIT = 1,
   parameter int   GAP_BITS     = 1,
   parameter logic IDLE_LEVEL   = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [PAT_W-1:0] pattern,
   input  logic [3:0]       len,
   input  logic [3:0]       reps,
   output logic             x_out,
   output logic             busy,
   output logic             done,
   output logic [7:0]       seg
);

   localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLKS_PER_BIT - 1);
   localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_BITS - 1);
   localparam logic [3:0] PAT_W4 = 4'(PAT_W);

   localparam logic [7:0] SEG_DASH = 8'b00000010;
   localparam logic [7:0] SEG_BUSY = 8'b00000011;
   localparam logic [7:0] SEG_DONE = 8'b11111111;

   typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

   state_t           state;
   logic [PAT_W-1:0] sh_pat;
   logic [3:0]       sh_len;
   logic [3:0]       rep_cnt;
   logic [3:0]       bit_idx;
   logic [DIV_W-1:0] div_cnt;
   logic [GAP_W-1:0] gap_cnt;

   logic [3:0]  len_clamped;
   logic [3:0]  first_idx;
   logic [3:0]  next_idx;
   logic [3:0]  last_idx;
   logic [15:0] pat_in_ext;
   logic [15:0] pat_ext;

   // Patterns are zero-extended to 16 bits so a 4-bit index is always in range.
   always_comb begin
      len_clamped = ((len == 4'd0) || (len > PAT_W4)) ? PAT_W4 : len;
      first_idx   = len_clamped - 4'd1;
      next_idx    = bit_idx - 4'd1;
      last_idx    = sh_len - 4'd1;
      pat_in_ext  = {{(16 - PAT_W){1'b0}}, pattern};
      pat_ext     = {{(16 - PAT_W){1'b0}}, sh_pat};
   end

   // div_cnt counts the remaining clocks of the current bit period; gap_cnt counts
   // the remaining idle bit periods between copies.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         sh_pat  <= '0;
         sh_len  <= '0;
         rep_cnt <= '0;
         bit_idx <= '0;
         div_cnt <= '0;
         gap_cnt <= '0;
         x_out   <= IDLE_LEVEL;
         busy    <= 1'b0;
         done    <= 1'b0;
         seg     <= SEG_DASH;
      end else begin
         case (state)
            IDLE: begin
               x_out <= IDLE_LEVEL;
               done  <= 1'b0;
               if (start && !abort) begin
                  state   <= SHIFT;
                  sh_pat  <= pattern;
                  sh_len  <= len_clamped;
                  rep_cnt <= reps;
                  bit_idx <= first_idx;
                  div_cnt <= DIV_MAX;
                  gap_cnt <= '0;
                  x_out   <= pat_in_ext[first_idx];
                  busy    <= 1'b1;
                  seg     <= SEG_BUSY;
               end
            end
            SHIFT: begin
               if (abort) begin
                  state   <= IDLE;
                  rep_cnt <= '0;
                  bit_idx <= '0;
                  div_cnt <= '0;
                  x_out   <= IDLE_LEVEL;
                  busy    <= 1'b0;
                  seg     <= SEG_DASH;
               end else if (div_cnt != '0) begin
                  div_cnt <= div_cnt - 1'b1;
               end else if (bit_idx != 4'd0) begin
                  bit_idx <= next_idx;
                  div_cnt <= DIV_MAX;
                  x_out   <= pat_ext[next_idx];
               end else if (rep_cnt != 4'd0) begin
                  state   <= GAP;
                  rep_cnt <= rep_cnt - 4'd1;
                  div_cnt <= DIV_MAX;
                  gap_cnt <= GAP_MAX;
                  x_out   <= IDLE_LEVEL;
               end else begin
                  state <= DONE;
                  x_out <= IDLE_LEVEL;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  seg   <= SEG_DONE;
               end
            end
            GAP: begin
               if (abort) begin
                  state   <= IDLE;
                  rep_cnt <= '0;
                  bit_idx <= '0;
                  div_cnt <= '0;
                  gap_cnt <= '0;
                  x_out   <= IDLE_LEVEL;
                  busy    <= 1'b0;
                  seg     <= SEG_DASH;
               end else if (div_cnt != '0) begin
                  div_cnt <= div_cnt - 1'b1;
               end else if (gap_cnt != '0) begin
                  gap_cnt <= gap_cnt - 1'b1;
                  div_cnt <= DIV_MAX;
               end else begin
                  state   <= SHIFT;
                  bit_idx <= last_idx;
                  div_cnt <= DIV_MAX;
                  x_out   <= pat_ext[last_idx];
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
               x_out <= IDLE_LEVEL;
            end
            default: begin
               state <= IDLE;
               x_out <= IDLE_LEVEL;
               busy  <= 1'b0;
               done  <= 1'b0;
               seg   <= SEG_DASH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: a table of transmissions checked cycle by
// cycle, plus hand-written reset, abort and start-blocking sequences.
module tb_serial_pattern_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic       start_a, start_b;
   logic       abort;
   logic [7:0] pattern;
   logic [3:0] len, reps;
   logic       x_a, busy_a, done_a;
   logic       x_b, busy_b, done_b;
   logic [7:0] seg_a, seg_b;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   serial_pattern_tx #(.PAT_W(8), .CLKS_PER_BIT(1), .GAP_BITS(1), .IDLE_LEVEL(1'b1)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .abort(abort), .pattern(pattern),
      .len(len), .reps(reps), .x_out(x_a), .busy(busy_a), .done(done_a), .seg(seg_a));

   serial_pattern_tx #(.PAT_W(8), .CLKS_PER_BIT(4), .GAP_BITS(1), .IDLE_LEVEL(1'b1)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .abort(abort), .pattern(pattern),
      .len(len), .reps(reps), .x_out(x_b), .busy(busy_b), .done(done_b), .seg(seg_b));

   typedef struct {
      logic [7:0]  pat;
      logic [3:0]  len;
      logic [3:0]  reps;
      bit          use_b;
      bit          repulse;
      int          n;
      logic [31:0] seq;
   } vec_t;

   vec_t vecs[6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Runs one table entry: start pulse, then every busy cycle, the done cycle and one after.
   task automatic applyStimulus(input vec_t v);
      logic xo, bo, dn;
      logic [7:0] sg;
      pattern = v.pat;
      len     = v.len;
      reps    = v.reps;
      if (v.use_b) start_b = 1'b1; else start_a = 1'b1;
      tick();
      start_a = 1'b0;
      start_b = 1'b0;
      for (int i = 0; i < v.n; i++) begin
         xo = v.use_b ? x_b : x_a;
         bo = v.use_b ? busy_b : busy_a;
         dn = v.use_b ? done_b : done_a;
         sg = v.use_b ? seg_b : seg_a;
         checkOutput($sformatf("x_out[%0d]", i), 32'(xo), 32'(v.seq[v.n - 1 - i]));
         checkOutput($sformatf("busy[%0d]", i), 32'(bo), 32'd1);
         checkOutput($sformatf("done_low[%0d]", i), 32'(dn), 32'd0);
         if (i == 0) checkOutput("seg_busy", 32'(sg), 32'h03);
         if (v.repulse && i == 2) begin
            pattern = 8'h00;
            len     = 4'd1;
            if (v.use_b) start_b = 1'b1; else start_a = 1'b1;
         end else begin
            start_a = 1'b0;
            start_b = 1'b0;
         end
         tick();
      end
      start_a = 1'b0;
      start_b = 1'b0;
      checkOutput("done_pulse", 32'(v.use_b ? done_b : done_a), 32'd1);
      checkOutput("done_busy", 32'(v.use_b ? busy_b : busy_a), 32'd0);
      checkOutput("done_x", 32'(v.use_b ? x_b : x_a), 32'd1);
      checkOutput("done_seg", 32'(v.use_b ? seg_b : seg_a), 32'hFF);
      tick();
      checkOutput("post_done", 32'(v.use_b ? done_b : done_a), 32'd0);
      checkOutput("post_seg", 32'(v.use_b ? seg_b : seg_a), 32'hFF);
      checkOutput("post_busy", 32'(v.use_b ? busy_b : busy_a), 32'd0);
   endtask

   initial begin
      int done_seen;
      vecs[0] = '{pat: 8'h03, len: 4'd3, reps: 4'd0, use_b: 0, repulse: 0, n: 3,  seq: 32'b011};
      vecs[1] = '{pat: 8'h03, len: 4'd3, reps: 4'd2, use_b: 0, repulse: 0, n: 11, seq: 32'b01110111011};
      vecs[2] = '{pat: 8'h02, len: 4'd2, reps: 4'd0, use_b: 1, repulse: 0, n: 8,  seq: 32'b11110000};
      vecs[3] = '{pat: 8'hA5, len: 4'd0, reps: 4'd0, use_b: 0, repulse: 1, n: 8,  seq: 32'b10100101};
      vecs[4] = '{pat: 8'hA5, len: 4'd9, reps: 4'd0, use_b: 0, repulse: 0, n: 8,  seq: 32'b10100101};
      vecs[5] = '{pat: 8'h00, len: 4'd1, reps: 4'd1, use_b: 0, repulse: 0, n: 3,  seq: 32'b010};

      reset = 1'b1; start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
      pattern = 8'h00; len = 4'd0; reps = 4'd0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      checkOutput("reset_x", 32'(x_a), 32'd1);
      checkOutput("reset_busy", 32'(busy_a), 32'd0);
      checkOutput("reset_done", 32'(done_a), 32'd0);
      checkOutput("reset_seg", 32'(seg_a), 32'h02);
      checkOutput("reset_seg_b", 32'(seg_b), 32'h02);

      foreach (vecs[k]) applyStimulus(vecs[k]);

      // Seg must keep showing the done code while idle until something changes it.
      tick();
      tick();
      checkOutput("seg_hold", 32'(seg_a), 32'hFF);

      // Reset in the middle of a transmission.
      pattern = 8'h00; len = 4'd8; reps = 4'd0; start_a = 1'b1;
      tick();
      start_a = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("midreset_x", 32'(x_a), 32'd1);
      checkOutput("midreset_busy", 32'(busy_a), 32'd0);
      checkOutput("midreset_done", 32'(done_a), 32'd0);
      checkOutput("midreset_seg", 32'(seg_a), 32'h02);

      // Start and reset on the same edge: reset wins.
      start_a = 1'b1; reset = 1'b1;
      tick();
      start_a = 1'b0; reset = 1'b0;
      checkOutput("start_vs_reset", 32'(busy_a), 32'd0);

      // Abort during the second bit of an 8-bit send.
      pattern = 8'h00; len = 4'd8; reps = 4'd0; start_a = 1'b1;
      tick();
      start_a = 1'b0;
      checkOutput("abort_bit0", 32'(x_a), 32'd0);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("abort_busy", 32'(busy_a), 32'd0);
      checkOutput("abort_x", 32'(x_a), 32'd1);
      checkOutput("abort_seg", 32'(seg_a), 32'h02);
      done_seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (done_a || busy_a) done_seen++;
         tick();
      end
      checkOutput("abort_no_done", 32'(done_seen), 32'd0);

      // Start together with abort in IDLE is refused.
      start_a = 1'b1; abort = 1'b1;
      tick();
      start_a = 1'b0; abort = 1'b0;
      checkOutput("start_abort_busy", 32'(busy_a), 32'd0);
      checkOutput("start_abort_x", 32'(x_a), 32'd1);
      tick();
      checkOutput("start_abort_busy2", 32'(busy_a), 32'd0);
      checkOutput("start_abort_seg", 32'(seg_a), 32'h02);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
